// File: rtl/decode_issue.sv
// ---------------------------------------------------------------------------
// decode_issue
//   Decode-and-issue stage in front of the 8-bit ALU. It decodes 16-bit
//   instruction words, reads operands from a 4x8 register file, forwards the
//   ALU result, stalls on unresolved RAW hazards and blocks fetch while a
//   branch shadow is active. ALU results are written back two edges after
//   issue.
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RST          asynchronous active-high reset
//   instr_word   instruction from fetch {op, rd, ra, rb, -, target}
//   instr_valid  instr_word is valid this cycle
//   instr_ready  combinational; the word is consumed when valid && ready
//   alu_out      ALU result bus (result of the op in the EXE stage)
//   A, B         registered operands to the ALU
//   instr        registered opcode to the ALU, 000 = bubble
//   branch_addr  registered branch target to the ALU
//   dbg_addr     register-file debug read address
//   dbg_data     combinational regfile[dbg_addr]
// ---------------------------------------------------------------------------
module decode_issue #(
    parameter int NREG      = 4,
    parameter int BR_SHADOW = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] instr_word,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  alu_out,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  instr,
    output logic [5:0]  branch_addr,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam int SW = $clog2(BR_SHADOW + 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_BR  = 3'b111;

    // Register file and pipeline tracking state
    logic [7:0]    r_regfile [NREG];
    logic          r_iss_valid;
    logic          r_iss_wr;
    logic [1:0]    r_iss_rd;
    logic          r_exe_valid;
    logic          r_exe_wr;
    logic [1:0]    r_exe_rd;
    logic [SW-1:0] r_shadow;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [2:0]    r_instr;
    logic [5:0]    r_br_addr;

    // Decode
    logic [2:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_ra;
    logic [1:0] w_rb;
    logic [5:0] w_target;
    logic       w_reads_a;
    logic       w_reads_b;
    logic       w_writes;
    logic       w_is_br;
    logic       w_stall;
    logic       w_ready;
    logic       w_fire;
    logic       w_exe_commit;
    logic [7:0] w_opa;
    logic [7:0] w_opb;
    logic       w_unused;

    assign w_op     = instr_word[15:13];
    assign w_rd     = instr_word[12:11];
    assign w_ra     = instr_word[10:9];
    assign w_rb     = instr_word[8:7];
    assign w_target = instr_word[5:0];
    assign w_unused = instr_word[6];

    // NOP and BR read nothing and write nothing; NOT reads ra only.
    assign w_writes  = (w_op != OP_NOP) && (w_op != OP_BR);
    assign w_reads_a = w_writes;
    assign w_reads_b = w_writes && (w_op != OP_NOT);
    assign w_is_br   = (w_op == OP_BR);

    // The ISS result is not on alu_out yet, so a consumer of it must wait one
    // cycle; after that the producer sits in EXE and is forwarded.
    assign w_stall = r_iss_valid && r_iss_wr &&
                     ((w_reads_a && (w_ra == r_iss_rd)) ||
                      (w_reads_b && (w_rb == r_iss_rd)));

    assign w_ready     = !RST && !w_stall && (r_shadow == '0);
    assign instr_ready = w_ready;
    assign w_fire      = instr_valid && w_ready;

    assign w_exe_commit = r_exe_valid && r_exe_wr;

    // Forwarding from EXE covers the writeback happening on this same edge.
    assign w_opa = (w_exe_commit && (r_exe_rd == w_ra)) ? alu_out : r_regfile[w_ra];
    assign w_opb = (w_exe_commit && (r_exe_rd == w_rb)) ? alu_out : r_regfile[w_rb];

    // Writeback: one flop bank per register so reset clears every entry.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_regfile[gi] <= 8'h00;
            end else if (w_exe_commit && (r_exe_rd == 2'(gi))) begin
                r_regfile[gi] <= alu_out;
            end
        end
    end

    // Tracking stages: EXE <- ISS, ISS <- newly issued op or bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_iss_valid <= 1'b0;
            r_iss_wr    <= 1'b0;
            r_iss_rd    <= 2'd0;
            r_exe_valid <= 1'b0;
            r_exe_wr    <= 1'b0;
            r_exe_rd    <= 2'd0;
        end else begin
            r_exe_valid <= r_iss_valid;
            r_exe_wr    <= r_iss_wr;
            r_exe_rd    <= r_iss_rd;
            r_iss_valid <= w_fire;
            r_iss_wr    <= w_fire && w_writes;
            r_iss_rd    <= w_rd;
        end
    end

    // Issue registers. Operands load only when the op actually reads them,
    // otherwise they hold, as do all of them on a bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_instr   <= OP_NOP;
            r_br_addr <= 6'h00;
        end else begin
            r_instr <= w_fire ? w_op : OP_NOP;
            if (w_fire && w_reads_a) begin
                r_a <= w_opa;
            end
            if (w_fire && w_reads_b) begin
                r_b <= w_opb;
            end
            if (w_fire && w_is_br) begin
                r_br_addr <= w_target;
            end
        end
    end

    // Branch shadow: blocks fetch for BR_SHADOW cycles after a BR issues.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shadow <= '0;
        end else if (w_fire && w_is_br) begin
            r_shadow <= SW'(BR_SHADOW);
        end else if (r_shadow != '0) begin
            r_shadow <= r_shadow - 1'b1;
        end
    end

    assign A           = r_a;
    assign B           = r_b;
    assign instr       = r_instr;
    assign branch_addr = r_br_addr;
    assign dbg_data    = r_regfile[dbg_addr];

endmodule

// File: tb/tb_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_decode_issue
//   Directed stimulus for decode_issue with a small ALU stand-in driving
//   alu_out. An architectural model (sequential program semantics plus a
//   pending-write list for register-file visibility) predicts every output;
//   a compare process checks the DUT each negative clock edge, and a few
//   hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_decode_issue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] instr_word = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_out;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  instr;
    logic [5:0]  branch_addr;
    logic [1:0]  dbg_addr = 2'd0;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad   = 0;

    decode_issue #(.NREG(4), .BR_SHADOW(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .instr_word  (instr_word),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_out     (alu_out),
        .A           (A),
        .B           (B),
        .instr       (instr),
        .branch_addr (branch_addr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return ~a;
            3'b101:  return a | b;
            3'b110:  return (a == b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // ALU stand-in: one registered stage from the issue registers.
    logic [7:0] alu_r;
    always @(posedge CLK or posedge RST) begin
        if (RST) alu_r <= 8'd0;
        else     alu_r <= alu_f(instr, A, B);
    end
    assign alu_out = alu_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    typedef struct {
        int         due;
        logic [1:0] rd;
        logic [7:0] val;
    } pw_t;

    logic [7:0] m_arch [4];   // program-order register values
    logic [7:0] m_vis  [4];   // what the register file should show now
    pw_t        m_pend [$];
    int         m_cyc    = 0;
    bit         m_last_w = 0; // op accepted at the previous edge writes
    logic [1:0] m_last_rd = 2'd0;
    int         m_shadow = 0;
    logic [7:0] e_a = 8'd0, e_b = 8'd0;
    logic [2:0] e_instr = 3'd0;
    logic [5:0] e_br = 6'd0;

    function automatic bit m_ready();
        logic [2:0] op = instr_word[15:13];
        bit ra_used = (op != 3'd0) && (op != 3'd7);
        bit rb_used = ra_used && (op != 3'd4);
        bit dep = m_last_w && ((ra_used && instr_word[10:9] == m_last_rd) ||
                               (rb_used && instr_word[8:7]  == m_last_rd));
        return !RST && (m_shadow == 0) && !dep;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_arch[i] = 8'd0;
            m_vis[i]  = 8'd0;
        end
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                for (int i = 0; i < 4; i++) begin
                    m_arch[i] = 8'd0;
                    m_vis[i]  = 8'd0;
                end
                m_pend.delete();
                m_last_w = 0;
                m_shadow = 0;
                e_a = 8'd0; e_b = 8'd0; e_instr = 3'd0; e_br = 6'd0;
            end else begin
                logic [2:0] op;
                logic [1:0] rd, ra, rb;
                bit acc;
                acc = instr_valid && m_ready();
                op = instr_word[15:13];
                rd = instr_word[12:11];
                ra = instr_word[10:9];
                rb = instr_word[8:7];
                m_cyc++;
                while (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
                    m_vis[m_pend[0].rd] = m_pend[0].val;
                    void'(m_pend.pop_front());
                end
                if (acc) begin
                    e_instr = op;
                    if (op != 3'd0 && op != 3'd7) e_a = m_arch[ra];
                    if (op != 3'd0 && op != 3'd7 && op != 3'd4) e_b = m_arch[rb];
                    if (op == 3'd7) begin
                        e_br = instr_word[5:0];
                        m_shadow = 2;
                    end
                    if (op != 3'd0 && op != 3'd7) begin
                        logic [7:0] v;
                        v = alu_f(op, m_arch[ra], m_arch[rb]);
                        m_arch[rd] = v;
                        m_pend.push_back('{due: m_cyc + 2, rd: rd, val: v});
                        m_last_w  = 1;
                        m_last_rd = rd;
                    end else begin
                        m_last_w = 0;
                    end
                end else begin
                    e_instr  = 3'd0;
                    m_last_w = 0;
                    if (m_shadow > 0) m_shadow--;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] dbg_seen [4];
    initial begin
        for (int i = 0; i < 4; i++) dbg_seen[i] = 8'hxx;
        forever begin
            @(negedge CLK);
            chk("instr_ready", 32'(instr_ready), 32'(m_ready()));
            chk("instr", 32'(instr), 32'(e_instr));
            chk("A", 32'(A), 32'(e_a));
            chk("B", 32'(B), 32'(e_b));
            chk("branch_addr", 32'(branch_addr), 32'(e_br));
            for (int a = 0; a < 4; a++) begin
                dbg_addr = 2'(a);
                #1;
                chk("dbg_data", 32'(dbg_data), 32'(m_vis[a]));
                dbg_seen[a] = dbg_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] w, output int tries);
        bit done = 0;
        bit r;
        tries = 0;
        instr_word  = w;
        instr_valid = 1'b1;
        while (!done && tries < 8) begin
            @(negedge CLK);
            r = instr_ready;
            tries++;
            @(posedge CLK);
            if (r) done = 1;
        end
        #1;
        instr_valid = 1'b0;
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int t;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        RST = 1'b0;

        // Build r1=1, r2=5, r3=3.
        send(16'hC800, t);               // EQ  r1,r0,r0 -> 1
        send(16'h3280, t);               // ADD r2,r1,r1 -> 2
        send(16'h3C80, t);               // ADD r3,r2,r1 -> 3
        send(16'h3700, t);               // ADD r2,r3,r2 -> 5
        send(16'h0000, t);               // NOP

        // Independent ADD r1,r2,r3
        send(16'h2D80, t);
        $display("txn ADD r1,r2,r3 tries=%0d A=%0h B=%0h instr=%0d", t, A, B, instr);
        chk("add_tries", 32'(t), 32'd1);
        chk("add_A", 32'(A), 32'd5);
        chk("add_B", 32'(B), 32'd3);
        chk("add_instr", 32'(instr), 32'd1);

        // Dependent SUB r0,r1,r2: one bubble then forwarded r1
        send(16'h4300, t);
        $display("txn SUB r0,r1,r2 tries=%0d A=%0h B=%0h", t, A, B);
        chk("sub_tries", 32'(t), 32'd2);
        chk("sub_A", 32'(A), 32'd8);
        chk("sub_B", 32'(B), 32'd5);

        // Distance two: ADD r1; AND r3,r3,r3; OR r0,r1,r1
        send(16'h2D80, t);
        send(16'h7F80, t);
        send(16'hA280, t);
        $display("txn OR r0,r1,r1 tries=%0d A=%0h B=%0h", t, A, B);
        chk("or_tries", 32'(t), 32'd1);
        chk("or_A", 32'(A), 32'd8);
        chk("or_B", 32'(B), 32'd8);

        // Compare then branch
        send(16'hC500, t);               // EQ r0,r2,r2 -> 1
        send(16'hE02A, t);               // BR 2A
        $display("txn BR tries=%0d branch_addr=%0h instr=%0d", t, branch_addr, instr);
        chk("br_tries", 32'(t), 32'd1);
        chk("br_addr", 32'(branch_addr), 32'h2A);
        chk("br_instr", 32'(instr), 32'd7);
        send(16'h9C00, t);               // NOT r3,r2 -> FA, waits out the shadow
        $display("txn NOT r3,r2 tries=%0d A=%0h", t, A);
        chk("shadow_tries", 32'(t), 32'd3);

        // Idle and drain
        idle(3);
        @(posedge CLK);
        $display("txn idle regs r0=%0h r1=%0h r2=%0h r3=%0h", dbg_seen[0], dbg_seen[1], dbg_seen[2], dbg_seen[3]);
        chk("idle_r0", 32'(dbg_seen[0]), 32'h01);
        chk("idle_r1", 32'(dbg_seen[1]), 32'h08);
        chk("idle_r2", 32'(dbg_seen[2]), 32'h05);
        chk("idle_r3", 32'(dbg_seen[3]), 32'hFA);
        #1;

        // Reset mid-stream with ops in flight
        send(16'h3700, t);               // ADD r2,r3,r2
        send(16'h7F80, t);               // AND r3,r3,r3
        RST = 1'b1;
        #1;
        $display("txn reset A=%0h B=%0h instr=%0d ready=%0d", A, B, instr, instr_ready);
        chk("mrst_A", 32'(A), 32'd0);
        chk("mrst_B", 32'(B), 32'd0);
        chk("mrst_instr", 32'(instr), 32'd0);
        chk("mrst_br", 32'(branch_addr), 32'd0);
        chk("mrst_ready", 32'(instr_ready), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(3);
        @(posedge CLK);
        for (int i = 0; i < 4; i++) chk("post_rst_reg", 32'(dbg_seen[i]), 32'd0);
        #1;

        // First issue after reset
        send(16'hC800, t);               // EQ r1,r0,r0 -> 1
        $display("txn post-reset EQ tries=%0d A=%0h B=%0h instr=%0d", t, A, B, instr);
        chk("prst_tries", 32'(t), 32'd1);
        chk("prst_instr", 32'(instr), 32'd6);
        chk("prst_A", 32'(A), 32'd0);
        idle(3);
        @(posedge CLK);
        chk("prst_r1", 32'(dbg_seen[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage that sits directly upstream of the 8-bit ALU in the pipelined CPU. It accepts 16-bit instruction words from fetch and reads operands from a 4×8 register file. It issues registered `A`, `B`, `instr` and `branch_addr` to the ALU, and writes the ALU result back into the register file two cycles after issue. It tracks in-flight destinations, forwards the ALU result, stalls on unresolved RAW hazards, and holds off fetch during the branch shadow.

## Interface
- `NREG`, 4: register count; `rd`/`ra`/`rb` fields are 2 bits.
- `BR_SHADOW`, 2: cycles `instr_ready` stays low after a branch issues.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `instr_word` input 16: instruction from fetch. Fields:
  - [15:13] op
  - [12:11] rd
  - [10:9] ra
  - [8:7] rb
  - [5:0] branch target (op 111 only)
- `instr_valid` input 1: `instr_word` is valid this cycle.
- `instr_ready` output 1: combinational; the word is consumed on an edge where `instr_valid && instr_ready`.
- `alu_out` input 8: ALU result bus.
- `A`, `B` output 8: registered operands to the ALU.
- `instr` output 3: registered opcode to the ALU; 000 = bubble.
- `branch_addr` output 6: registered branch target to the ALU.
- `dbg_addr` input 2: register-file debug read address.
- `dbg_data` output 8: combinational `regfile[dbg_addr]`.

## Operation
- Writer ops: 001 ADD, 010 SUB, 011 AND, 100 NOT, 101 OR, 110 EQ. These write `rd`.
- Non-writer ops: 000 NOP and 111 BR. These never write.
- Operand sources: op 100 reads `ra` only. Ops 000 and 111 read nothing. All others read `ra` and `rb`.
- Tracking stages (each holds valid, rd, writes):
  - ISS: the op currently in the ALU input registers.
  - EXE: the op whose result is currently on `alu_out`.
  - Every edge: EXE ← ISS; ISS ← the newly issued op, or invalid on a bubble.
- Writeback: on each edge where EXE is valid and a writer, `regfile[EXE.rd] <= alu_out`.
- Operand read, per source register:
  - EXE writer with matching rd → use `alu_out` (forward).
  - Otherwise → use `regfile`. The regfile write for the same edge is bypassed by the forward, so no stale read occurs.
- Stall: assert when an ISS writer's rd matches any source register of `instr_word`. The result does not exist yet.
  - During a stall, `instr_ready=0` and a bubble issues: `instr<=000`; `A`, `B`, `branch_addr` hold.
  - A dependent back-to-back pair costs exactly one bubble.
- Branch: issuing op 111 loads `branch_addr <= instr_word[5:0]` and starts the shadow counter at `BR_SHADOW`.
  - While the counter is nonzero, `instr_ready=0`, a bubble issues, and the counter decrements.
  - Fetch redirect is fetch's job; it uses the ALU `branch_flag` and `out`.
- BR reads no registers and so never stalls. A valid BR immediately after an EQ issues on the next cycle, preserving the ALU's `eq_flag`. Fetch must present it back-to-back.
- `instr_ready = !RST && !stall && (shadow==0)`.
- Empty input: when `instr_valid=0`, a bubble issues and ISS becomes invalid.
- Writes to any rd are allowed; all 4 registers are general purpose, with no hardwired zero.

## Timing
- Issue at edge N, ALU result on `alu_out` after edge N+1, regfile written at edge N+2.
- Forward window: a consumer issuing at edge N+2 receives `alu_out` directly.
- RST assertion clears everything immediately, independent of `CLK`:
  - `A=B=0`, `instr=000`, `branch_addr=0`
  - all regfile entries 0
  - ISS and EXE invalid, shadow=0
  - `instr_ready` low while RST is high
- Reset mid-operation: in-flight results are discarded, with no write after release. First issue is possible on the first edge after RST deasserts.
- Simultaneous events:
  - An EXE writeback and a debug read of the same register: `dbg_data` shows the old value until the edge.
  - The same rd held in both ISS and EXE: the younger (ISS) result wins at its own writeback, with no ordering hazard.

## Test plan
- Reset: assert RST mid-stream with ops in flight → all outputs 0, `instr=000`, `dbg_data=0` for every address, no later writes.
- Independent stream: preload r2=5, r3=3 via prior ops, then issue ADD r1,r2,r3 (16'h2D80) → `A=5`, `B=3`, `instr=001`; r1=8 two edges later; `instr_ready` stays 1.
- RAW back-to-back: ADD r1,r2,r3 followed by SUB r0,r1,r2 → one bubble (`instr=000`, `instr_ready=0` for one cycle), then `A=8` forwarded from `alu_out`, `B=5`; r0=3.
- RAW distance two: ADD r1, then an independent op, then OR r0,r1,r1 → no stall; `A=B=8` via the forward path.
- Compare+branch: EQ r0,r2,r2 then BR target 6'h2A → BR issues on the next cycle with `branch_addr=2A`; `instr_ready` low for exactly 2 cycles; no write to any register from BR.
- Idle: `instr_valid=0` for 3 cycles → `instr=000` each cycle and the regfile is unchanged after pending writebacks drain.
